mpu_load: RTL

//  External memory --> matrix register file. Accepts a matrix one floating point element per

---
 rtl/mpu_load_if.sv | 20 ++
 rtl/mpu_load.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mpu_load_if.sv
// rtl/mpu_load_if.sv - element stream from external memory into the matrix load path
interface mpu_load_if #(
    parameter int FPBITS = 31
) ();
    logic              mem_load_valid_in;
    logic [FPBITS:0]   mem_load_element_in;
    logic              mem_load_ready_out;

    modport master (
        output mem_load_valid_in,
        output mem_load_element_in,
        input  mem_load_ready_out
    );

    modport slave (
        input  mem_load_valid_in,
        input  mem_load_element_in,
        output mem_load_ready_out
    );
endinterface

// File: rtl/mpu_load.sv
// rtl/mpu_load.sv - memory to matrix register file loader, row-major element writes
// Optional MPU_LOAD_SIZE_CHECK_EN: reject zero/oversized starts with a load_error_out pulse.
module mpu_load #(
    parameter int FPBITS          = 31,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_BITS = 3
`ifdef MPU_LOAD_SIZE_CHECK_EN
    ,parameter int MROWS_MAX      = 3
    ,parameter int NCOLS_MAX      = 3
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mpu_load_if.slave                  mem,
    input  logic                       mem_load_en_in,
    input  logic [MBITS:0]             mem_m_load_size_in,
    input  logic [NBITS:0]             mem_n_load_size_in,
    input  logic [MATRIX_REG_BITS:0]   mem_load_addr_in,
    output logic                       reg_load_en_out,
    output logic [FPBITS:0]            reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output logic                       load_busy_out,
    output logic                       load_done_out
`ifdef MPU_LOAD_SIZE_CHECK_EN
    ,output logic                      load_error_out
`endif
);
    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_MATRIX,
        LOAD_DONE
    } state_t;

    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);
`ifdef MPU_LOAD_SIZE_CHECK_EN
    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(MROWS_MAX);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(NCOLS_MAX);
`endif

    state_t          state;
    logic [MBITS:0]  row_ptr;
    logic [NBITS:0]  col_ptr;
    logic            accept;
    logic            last_col;
    logic            last_row;
    logic            size_zero;

    assign mem.mem_load_ready_out = (state == LOAD_MATRIX);
    assign load_busy_out          = (state != LOAD_IDLE);
    assign accept                 = mem.mem_load_valid_in && mem.mem_load_ready_out;
    assign last_col               = (col_ptr == reg_n_load_size_out - N_ONE);
    assign last_row               = (row_ptr == reg_m_load_size_out - M_ONE);
    assign size_zero              = (mem_m_load_size_in == '0) || (mem_n_load_size_in == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= LOAD_IDLE;
            row_ptr              <= '0;
            col_ptr              <= '0;
            reg_load_en_out      <= 1'b0;
            reg_load_element_out <= '0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_load_addr_out    <= '0;
            reg_m_load_size_out  <= '0;
            reg_n_load_size_out  <= '0;
            load_done_out        <= 1'b0;
`ifdef MPU_LOAD_SIZE_CHECK_EN
            load_error_out       <= 1'b0;
`endif
        end else begin
            reg_load_en_out <= 1'b0;
            load_done_out   <= 1'b0;
`ifdef MPU_LOAD_SIZE_CHECK_EN
            load_error_out  <= 1'b0;
`endif
            case (state)
                LOAD_IDLE: begin
                    if (mem_load_en_in) begin
`ifdef MPU_LOAD_SIZE_CHECK_EN
                        if (size_zero || (mem_m_load_size_in > M_MAX) ||
                            (mem_n_load_size_in > N_MAX)) begin
                            load_error_out <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            reg_m_load_size_out <= mem_m_load_size_in;
                            reg_n_load_size_out <= mem_n_load_size_in;
                            reg_load_addr_out   <= mem_load_addr_in;
                            row_ptr             <= '0;
                            col_ptr             <= '0;
                            // Empty matrix still signals completion so callers never stall
                            if (size_zero) begin
                                state         <= LOAD_DONE;
                                load_done_out <= 1'b1;
                            end else begin
                                state <= LOAD_MATRIX;
                            end
                        end
                    end
                end
                LOAD_MATRIX: begin
                    if (accept) begin
                        reg_load_en_out      <= 1'b1;
                        reg_load_element_out <= mem.mem_load_element_in;
                        reg_i_load_loc_out   <= row_ptr;
                        reg_j_load_loc_out   <= col_ptr;
                        if (last_col) begin
                            col_ptr <= '0;
                            // Done pulse lands on the same cycle as the final write
                            if (last_row) begin
                                state         <= LOAD_DONE;
                                load_done_out <= 1'b1;
                            end else begin
                                row_ptr <= row_ptr + M_ONE;
                            end
                        end else begin
                            col_ptr <= col_ptr + N_ONE;
                        end
                    end
                end
                LOAD_DONE: begin
                    row_ptr <= '0;
                    col_ptr <= '0;
                    state   <= LOAD_IDLE;
                end
                default: state <= LOAD_IDLE;
            endcase
        end
    end
endmodule
